uart_rx_fifo: RTL and testbench

//   Parametrised UART receiver, successor to the fixed 8N1 receiver.
//   - Configurable data width, stop bits, oversampling and baud.
//   - 3-sample majority vote; false-start rejection; framing/overrun detection.
//   - FIFO buffering with first-word-fall-through read.
//   - Sits between the board RXD pin and UART_Top / host-side logic.

---
 rtl/uart_rx_fifo.sv | 252 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with majority-vote bit sampling and a first-word-fall-through FIFO.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN.
module uart_rx_fifo #(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic                          i_Rx,
  input  logic                          i_fRead,
  input  logic                          i_fClrErr,
  output logic [DATA_BITS-1:0]          o_Data,
  output logic                          o_fValid,
  output logic [$clog2(FIFO_DEPTH):0]   o_Count,
  output logic                          o_fDone,
  output logic                          o_fFrameErr,
  output logic                          o_fOverrun,
  output logic                          o_fParityErr
);

  localparam int unsigned DIV_RAW  = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int unsigned DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned DW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned TW       = $clog2(OVERSAMPLE);
  localparam int unsigned BIT_CLKS = OVERSAMPLE * DIV;
  localparam int unsigned HW       = $clog2(BIT_CLKS + 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned BW       = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic                   r_rx_meta, r_rx_sync, r_rx_prev;
  logic [DW-1:0]          r_div_cnt;
  logic [TW-1:0]          r_tick_cnt;
  logic [1:0]             r_votes;
  logic [BW-1:0]          r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_BITS-1:0]   r_shift, w_shift_nxt;
  logic [HW-1:0]          r_hi_cnt, w_hi_nxt;
  logic                   w_tick, w_centre, w_vote, w_fall;
  logic                   w_restart, w_wr_req, w_frame_set, w_par_set;

  logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
  logic [CW-1:0]          w_count_nxt;
  logic [DATA_BITS-1:0]   w_head_nxt;
  logic                   w_rd, w_wr, w_full, w_ovr_set;

  // Two-flop synchroniser plus a delayed copy for start-edge detection
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_Rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  assign w_fall   = r_rx_prev & ~r_rx_sync;
  assign w_tick   = (r_div_cnt == DW'(DIV - 1));
  assign w_centre = w_tick && (r_tick_cnt == TW'(OVERSAMPLE / 2 + 1));
  assign w_vote   = (r_votes[0] & r_votes[1]) | (r_votes[0] & r_rx_sync) |
                    (r_votes[1] & r_rx_sync);

  // Oversample tick generator; the third vote is taken live at the decision tick
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_votes    <= 2'b11;
    end else if (w_restart) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= (r_tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : r_tick_cnt + TW'(1);
      if (r_tick_cnt == TW'(OVERSAMPLE / 2 - 1)) r_votes[0] <= r_rx_sync;
      if (r_tick_cnt == TW'(OVERSAMPLE / 2))     r_votes[1] <= r_rx_sync;
    end else begin
      r_div_cnt  <= r_div_cnt + DW'(1);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_hi_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_hi_cnt  <= w_hi_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic w_par_exp;
  assign w_par_exp = (^r_shift) ^ 1'(PARITY_ODD);
`else
  logic w_unused_parity_odd;
  assign w_unused_parity_odd = 1'(PARITY_ODD);
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_hi_nxt      = r_hi_cnt;
    w_restart     = 1'b0;
    w_wr_req      = 1'b0;
    w_frame_set   = 1'b0;
    w_par_set     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_restart   = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_centre) begin
          w_bit_cnt_nxt = '0;
          w_state_nxt   = w_vote ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_centre) begin
          w_shift_nxt = {w_vote, r_shift[DATA_BITS-1:1]};
          if (r_bit_cnt == BW'(DATA_BITS - 1)) begin
            w_bit_cnt_nxt = '0;
`ifdef UART_RX_PARITY_EN
            w_state_nxt   = S_PARITY;
`else
            w_state_nxt   = S_STOP;
`endif
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (w_centre) begin
          w_par_set     = (w_vote != w_par_exp);
          w_bit_cnt_nxt = '0;
          w_state_nxt   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (w_centre) begin
          if (!w_vote) begin
            w_frame_set = 1'b1;
            w_hi_nxt    = '0;
            w_state_nxt = S_WAIT_HIGH;
          end else if (r_bit_cnt == BW'(STOP_BITS - 1)) begin
            w_wr_req    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_bit_cnt_nxt = r_bit_cnt + BW'(1);
          end
        end
      end
      S_WAIT_HIGH: begin
        // Break tolerance: require one unbroken bit time of idle line
        if (!r_rx_sync) begin
          w_hi_nxt = '0;
        end else if (r_hi_cnt == HW'(BIT_CLKS - 1)) begin
          w_hi_nxt    = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_hi_nxt = r_hi_cnt + HW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd         = i_fRead & o_fValid;
  assign w_full       = (o_Count == CW'(FIFO_DEPTH));
  assign w_wr         = w_wr_req & (~w_full | w_rd);
  assign w_ovr_set    = w_wr_req & w_full & ~w_rd;
  assign w_count_nxt  = o_Count + CW'(w_wr) - CW'(w_rd);
  assign w_rd_ptr_nxt = w_rd ? r_rd_ptr + AW'(1) : r_rd_ptr;
  // Bypass the incoming byte when it becomes the new head
  assign w_head_nxt   = (w_wr && (w_rd_ptr_nxt == r_wr_ptr)) ? r_shift : r_mem[w_rd_ptr_nxt];

  always_ff @(posedge Clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_shift;
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      o_Count  <= '0;
      o_fValid <= 1'b0;
      o_Data   <= '0;
      o_fDone  <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      o_Count  <= w_count_nxt;
      o_fValid <= (w_count_nxt != '0);
      o_Data   <= w_head_nxt;
      o_fDone  <= w_wr;
    end
  end

  // Sticky flags; a set wins over a simultaneous clear
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      o_fFrameErr  <= 1'b0;
      o_fOverrun   <= 1'b0;
      o_fParityErr <= 1'b0;
    end else begin
      o_fFrameErr  <= w_frame_set | (o_fFrameErr & ~i_fClrErr);
      o_fOverrun   <= w_ovr_set   | (o_fOverrun  & ~i_fClrErr);
`ifdef UART_RX_PARITY_EN
      o_fParityErr <= w_par_set   | (o_fParityErr & ~i_fClrErr);
`else
      o_fParityErr <= 1'b0;
`endif
    end
  end

`ifndef UART_RX_PARITY_EN
  logic w_unused_par_set;
  assign w_unused_par_set = w_par_set;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised self-checking bench for uart_rx_fifo against a queue-based reference model.
// Runs at a faster line rate (96 clk/bit) to keep the 17-frame overrun case short.
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ  = 50000000;
  localparam int unsigned BAUD    = 460800;
  localparam int unsigned OS      = 16;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned DIV_T   = ((CLK_HZ / (BAUD * OS)) < 1) ? 1 : CLK_HZ / (BAUD * OS);
  localparam int unsigned BIT_CLK = OS * DIV_T;

  logic       Clk, Rst, i_Rx, i_fRead, i_fClrErr;
  logic [7:0] o_Data;
  logic       o_fValid, o_fDone, o_fFrameErr, o_fOverrun, o_fParityErr;
  logic [4:0] o_Count;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned n_done   = 0;
`ifdef UART_RX_PARITY_EN
  logic bad_par = 1'b0;
`endif

  uart_rx_fifo #(
    .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
    .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)
  ) dut (
    .Clk(Clk), .Rst(Rst), .i_Rx(i_Rx), .i_fRead(i_fRead), .i_fClrErr(i_fClrErr),
    .o_Data(o_Data), .o_fValid(o_fValid), .o_Count(o_Count), .o_fDone(o_fDone),
    .o_fFrameErr(o_fFrameErr), .o_fOverrun(o_fOverrun), .o_fParityErr(o_fParityErr)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  always @(negedge Clk) if (!Rst && o_fDone) n_done++;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic line(input logic v, input int unsigned n);
    i_Rx = v;
    repeat (n) @(negedge Clk);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v);
    line(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) line(d[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
    line((^d) ^ bad_par, BIT_CLK);
`endif
    line(stop_v, BIT_CLK);
    i_Rx = 1'b1;
  endtask

  task automatic pop(output logic [7:0] d);
    d = o_Data;
    i_fRead = 1'b1;
    @(negedge Clk);
    i_fRead = 1'b0;
  endtask

  task automatic clr_err();
    i_fClrErr = 1'b1;
    @(negedge Clk);
    i_fClrErr = 1'b0;
    @(negedge Clk);
  endtask

  initial begin
    logic [7:0]  d, rd;
    logic [7:0]  q[$];
    int unsigned d0, acc;
    logic        exp_ovr;

    Rst = 1'b1; i_Rx = 1'b1; i_fRead = 1'b0; i_fClrErr = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_data", o_Data, 0);
    chk("rst_valid", o_fValid, 0);
    chk("rst_count", o_Count, 0);
    chk("rst_done", o_fDone, 0);
    chk("rst_flags", {o_fFrameErr, o_fOverrun, o_fParityErr}, 0);
    Rst = 1'b0;
    repeat (5) @(negedge Clk);
    chk("post_rst_count", o_Count, 0);

    // single frame
    d0 = n_done;
    send(8'h3C, 1'b1);
    repeat (BIT_CLK) @(negedge Clk);
    chk("t1_done", n_done - d0, 1);
    chk("t1_data", o_Data, 8'h3C);
    chk("t1_valid", o_fValid, 1);
    chk("t1_count", o_Count, 1);
    chk("t1_flags", {o_fFrameErr, o_fOverrun, o_fParityErr}, 0);
    pop(rd);
    chk("t1_pop", rd, 8'h3C);
    chk("t1_empty", o_Count, 0);

    // back-to-back frames
    send(8'h3C, 1'b1);
    send(8'hE5, 1'b1);
    repeat (BIT_CLK / 2) @(negedge Clk);
    chk("t2_count2", o_Count, 2);
    pop(rd);
    chk("t2_rd1", rd, 8'h3C);
    chk("t2_count1", o_Count, 1);
    pop(rd);
    chk("t2_rd2", rd, 8'hE5);
    chk("t2_count0", o_Count, 0);
    chk("t2_valid0", o_fValid, 0);

    // read while empty
    i_fRead = 1'b1;
    @(negedge Clk);
    i_fRead = 1'b0;
    @(negedge Clk);
    chk("empty_rd_count", o_Count, 0);
    chk("empty_rd_valid", o_fValid, 0);

    // false start
    d0 = n_done;
    line(1'b0, 5);
    line(1'b1, 2 * BIT_CLK);
    chk("glitch_done", n_done - d0, 0);
    chk("glitch_count", o_Count, 0);
    chk("glitch_flags", {o_fFrameErr, o_fOverrun, o_fParityErr}, 0);

    // framing error, recovery after idle
    send(8'hA5, 1'b0);
    line(1'b1, BIT_CLK + BIT_CLK / 2);
    chk("fe_flag", o_fFrameErr, 1);
    chk("fe_count", o_Count, 0);
    send(8'h11, 1'b1);
    repeat (BIT_CLK) @(negedge Clk);
    chk("fe_next_count", o_Count, 1);
    chk("fe_next_data", o_Data, 8'h11);
    pop(rd);
    clr_err();
    chk("fe_clear", o_fFrameErr, 0);

    // reset mid-frame discards the partial byte
    d0 = n_done;
    line(1'b0, 3 * BIT_CLK);
    Rst = 1'b1;
    repeat (2) @(negedge Clk);
    chk("midrst_count", o_Count, 0);
    i_Rx = 1'b1;
    Rst = 1'b0;
    repeat (11 * BIT_CLK) @(negedge Clk);
    chk("midrst_done", n_done - d0, 0);
    chk("midrst_after", o_Count, 0);

    // overrun
    d0 = n_done;
    for (int i = 1; i <= 17; i++) send(8'(i), 1'b1);
    repeat (BIT_CLK) @(negedge Clk);
    chk("ovr_count", o_Count, DEPTH);
    chk("ovr_flag", o_fOverrun, 1);
    chk("ovr_head", o_Data, 8'h01);
    chk("ovr_done", n_done - d0, DEPTH);
    clr_err();
    chk("ovr_clear", o_fOverrun, 0);
    for (int i = 1; i <= 16; i++) begin
      pop(rd);
      chk("ovr_drain", rd, 32'(i));
    end
    chk("ovr_drained", o_Count, 0);

`ifdef UART_RX_PARITY_EN
    bad_par = 1'b1;
    send(8'h3C, 1'b1);
    repeat (BIT_CLK) @(negedge Clk);
    chk("par_bad_flag", o_fParityErr, 1);
    chk("par_bad_data", o_Data, 8'h3C);
    pop(rd);
    clr_err();
    bad_par = 1'b0;
    send(8'h3C, 1'b1);
    repeat (BIT_CLK) @(negedge Clk);
    chk("par_ok_flag", o_fParityErr, 0);
    pop(rd);
`endif

    // randomised traffic against the queue model
    d0 = n_done;
    acc = 0;
    exp_ovr = 1'b0;
    for (int k = 0; k < 24; k++) begin
      d = 8'($urandom);
      send(d, 1'b1);
      repeat (4) @(negedge Clk);
      if (q.size() < DEPTH) begin
        q.push_back(d);
        acc++;
      end else begin
        exp_ovr = 1'b1;
      end
      chk("rnd_count", o_Count, q.size());
      chk("rnd_valid", o_fValid, (q.size() != 0) ? 1 : 0);
      if (q.size() != 0) chk("rnd_head", o_Data, q[0]);
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) begin
        if (q.size() != 0) begin
          pop(rd);
          chk("rnd_pop", rd, q.pop_front());
        end
      end
      line(1'b1, $urandom_range(0, 2) * BIT_CLK / 2);
    end
    chk("rnd_done_total", n_done - d0, acc);
    chk("rnd_overrun", o_fOverrun, exp_ovr);
    chk("rnd_frame_err", o_fFrameErr, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
